serial_adder_subtractor: RTL and testbench
==========================================

SERIAL_ADDER_SUBTRACTOR -- requirements
Module: serial_adder_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-005 Port: a  input  WIDTH  operand A; captured on accepted start.
REQ-006 Port: b  input  WIDTH  operand B; captured on accepted start.
REQ-007 Port: opcode  input  1  operation select; 0 = add (A+B), 1 = subtract (A-B); captured on accepted start.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  one-cycle pulse; result, cout and overflow are valid.
REQ-010 Port: result  output  WIDTH  sum or difference, two's complement, modulo 2^WIDTH.
REQ-011 Port: cout  output  1  final carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned).
REQ-012 Port: overflow  output  1  signed overflow of the completed operation.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 Transitions:
- IDLE -> RUN on start=1.
- RUN -> DONE after exactly WIDTH bit cycles.
- DONE -> RUN on start=1; otherwise DONE -> IDLE.
REQ-015 Accepted start:
- captures a, b and opcode into internal registers.
- clears the bit counter.
- sets the carry register to opcode.
REQ-016 Processing order and slice:
- One bit per RUN cycle, LSB first.
- Slice inputs: a_bit, b_bit XOR opcode, carry register.
- Slice outputs: sum bit shifted into the result register from the MSB side; slice carry-out stored in the carry register.
REQ-017 Latency: start accepted at edge k -> done=1 during the cycle after edge k+WIDTH (WIDTH+1 cycles from start to done).
REQ-018 Carry history: on the last RUN cycle, the carry into the MSB slice SHALL be retained.
- overflow = carry-into-MSB XOR cout.
REQ-019 done SHALL be high only in DONE; busy SHALL be high only in RUN.
REQ-020 Output hold: result, cout and overflow SHALL hold their last completed values until the next operation completes; they SHALL NOT show partial values.
REQ-021 start while in RUN SHALL be ignored; the operation in flight and its captured operands are unaffected.
REQ-022 Input changes on a, b and opcode after acceptance SHALL NOT affect the operation in flight.
REQ-023 start=1 in DONE SHALL be accepted (back-to-back); done SHALL still pulse exactly one cycle per operation.

Reset
REQ-024 rst=1 SHALL immediately force:
- state = IDLE.
- busy, done, cout, overflow = 0.
- result = 0.
- carry and counter = 0.
REQ-025 rst asserted mid-RUN SHALL abort the operation; no done SHALL be produced for it.
REQ-026 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-027 A shared package SHALL hold the FSM state enum and the opcode constants OP_ADD=0, OP_SUB=1.
REQ-028 The bit slice SHALL be one combinational sub-module, full_adder_slice (a, b, cin, opcode -> sum, cout), instantiated once.
REQ-029 The counter width SHALL be clog2(WIDTH)+1 bits.

Verification
REQ-030 WIDTH=8 add: 5+3 -> done after 9 cycles, result=0x08, cout=0, overflow=0.
REQ-031 WIDTH=8 add: 0x7F+0x01 -> result=0x80, cout=0, overflow=1.
REQ-032 WIDTH=8 subtract:
- 3-5 -> result=0xFE, cout=0, overflow=0.
- 0x80-0x01 -> result=0x7F, cout=1, overflow=1.
REQ-033 WIDTH=8:
- start pulses during RUN are ignored; a changes mid-RUN -> result is unchanged.
- back-to-back start in DONE -> two done pulses exactly 9 cycles apart.
REQ-034 WIDTH=8, rst mid-RUN:
- rst at bit cycle 4 -> all outputs 0 immediately; no done.
- next 0xFF+0x01 -> result=0x00, cout=1, overflow=0.
REQ-035 WIDTH=4, 0x7-0x8 -> done after 5 cycles, result=0xF, cout=0, overflow=1.

Source files
------------

// File: rtl/serial_adder_subtractor_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_subtractor_if.sv
// Request/response bundle between a requester and the serial adder/subtractor.
interface serial_adder_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             opcode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, opcode,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, a, b, opcode,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_adder_subtractor_slice.sv
// One-bit full adder; b is inverted for subtract so A-B = A + ~B + 1.
module full_adder_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic opcode,
    output logic sum,
    output logic cout
);
    logic bx;

    assign bx   = b ^ opcode;
    assign sum  = a ^ bx ^ cin;
    assign cout = (a & bx) | (cin & (a ^ bx));
endmodule

// File: rtl/serial_adder_subtractor.sv
// Bit-serial add/subtract, LSB first, one bit per RUN cycle.
module serial_adder_subtractor
    import serial_adder_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst,
    serial_adder_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, result_q;
    logic             op_q, carry_q, cout_q, ovf_q;
    logic [CW-1:0]    cnt_q;
    logic             load, step, last;
    logic             s_sum, s_cout;

    full_adder_slice u_slice (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .cin    (carry_q),
        .opcode (op_q),
        .sum    (s_sum),
        .cout   (s_cout)
    );

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            result_q <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (load) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            op_q    <= bus.opcode;
            carry_q <= bus.opcode;
            cnt_q   <= '0;
        end else if (step) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            sum_sh  <= {s_sum, sum_sh[WIDTH-1:1]};
            carry_q <= s_cout;
            cnt_q   <= cnt_q + CW'(1);
            // On the MSB cycle carry_q is the carry into the MSB slice.
            if (last) begin
                result_q <= {s_sum, sum_sh[WIDTH-1:1]};
                cout_q   <= s_cout;
                ovf_q    <= carry_q ^ s_cout;
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Directed checks for serial_adder_subtractor at WIDTH=8 and WIDTH=4.
module tb_serial_adder_subtractor;
    import serial_adder_subtractor_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    serial_adder_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_adder_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_adder_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    task automatic launch8(input logic [7:0] av, input logic [7:0] bv, input logic op);
        @(negedge clk);
        bus8.start  = 1'b1;
        bus8.a      = av;
        bus8.b      = bv;
        bus8.opcode = op;
        @(negedge clk);
        bus8.start  = 1'b0;
    endtask

    // cycles counts the start cycle as 1; a bound of 40 keeps the bench finite.
    task automatic wait_done8(output int cycles);
        cycles = 1;
        while (bus8.done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.opcode = OP_ADD;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.opcode = OP_ADD;
        @(negedge clk);
        vectors++;
        if ({bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset8 outputs: got %h want 000",
                     {bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow});
        end
        vectors++;
        if ({bus4.busy, bus4.done, bus4.result, bus4.cout, bus4.overflow} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset4 outputs: got %h want 00",
                     {bus4.busy, bus4.done, bus4.result, bus4.cout, bus4.overflow});
        end
        rst = 1'b0;
    endtask

    task automatic test_add;
        int cyc;
        launch8(8'd5, 8'd3, OP_ADD);
        vectors++;
        if (bus8.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL add_busy: got %b want 1", bus8.busy);
        end
        wait_done8(cyc);
        vectors++;
        if (cyc !== 9) begin
            miscompares++;
            $display("FAIL add_latency: got %0d want 9", cyc);
        end
        vectors++;
        if ({bus8.result, bus8.cout, bus8.overflow} !== {8'h08, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL add_5_3 {res,cout,ovf}: got %h want %h",
                     {bus8.result, bus8.cout, bus8.overflow}, {8'h08, 2'b00});
        end
        @(negedge clk);
        vectors++;
        if ({bus8.done, bus8.busy, bus8.result} !== {2'b00, 8'h08}) begin
            miscompares++;
            $display("FAIL add_pulse_hold {done,busy,res}: got %h want %h",
                     {bus8.done, bus8.busy, bus8.result}, {2'b00, 8'h08});
        end
        launch8(8'h7F, 8'h01, OP_ADD);
        wait_done8(cyc);
        vectors++;
        if ({bus8.result, bus8.cout, bus8.overflow} !== {8'h80, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL add_7f_01 {res,cout,ovf}: got %h want %h",
                     {bus8.result, bus8.cout, bus8.overflow}, {8'h80, 2'b01});
        end
    endtask

    task automatic test_sub;
        int cyc;
        launch8(8'd3, 8'd5, OP_SUB);
        wait_done8(cyc);
        vectors++;
        if ({bus8.result, bus8.cout, bus8.overflow} !== {8'hFE, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_3_5 {res,cout,ovf}: got %h want %h",
                     {bus8.result, bus8.cout, bus8.overflow}, {8'hFE, 2'b00});
        end
        launch8(8'h80, 8'h01, OP_SUB);
        wait_done8(cyc);
        vectors++;
        if ({bus8.result, bus8.cout, bus8.overflow} !== {8'h7F, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_80_01 {res,cout,ovf}: got %h want %h",
                     {bus8.result, bus8.cout, bus8.overflow}, {8'h7F, 2'b11});
        end
    endtask

    task automatic test_ignore_start;
        int cyc;
        launch8(8'h12, 8'h34, OP_ADD);
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.opcode = OP_SUB;
        @(negedge clk);
        bus8.start = 1'b0; bus8.a = 8'h00;
        vectors++;
        if (bus8.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_busy: got %b want 1", bus8.busy);
        end
        wait_done8(cyc);
        vectors++;
        if ({bus8.result, bus8.cout, bus8.overflow} !== {8'h46, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL ignore_start {res,cout,ovf}: got %h want %h",
                     {bus8.result, bus8.cout, bus8.overflow}, {8'h46, 2'b00});
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        launch8(8'h10, 8'h20, OP_ADD);
        wait_done8(cyc);
        vectors++;
        if (bus8.result !== 8'h30) begin
            miscompares++;
            $display("FAIL b2b_first res: got %h want 30", bus8.result);
        end
        bus8.start = 1'b1; bus8.a = 8'h90; bus8.b = 8'h10; bus8.opcode = OP_SUB;
        @(negedge clk);
        bus8.start = 1'b0;
        vectors++;
        if ({bus8.done, bus8.busy, bus8.result} !== {2'b01, 8'h30}) begin
            miscompares++;
            $display("FAIL b2b_restart {done,busy,res}: got %h want %h",
                     {bus8.done, bus8.busy, bus8.result}, {2'b01, 8'h30});
        end
        wait_done8(cyc);
        vectors++;
        if (cyc !== 9) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d want 9", cyc);
        end
        vectors++;
        if ({bus8.result, bus8.cout, bus8.overflow} !== {8'h80, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_second {res,cout,ovf}: got %h want %h",
                     {bus8.result, bus8.cout, bus8.overflow}, {8'h80, 2'b10});
        end
        @(negedge clk);
        vectors++;
        if (bus8.done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_pulse_width: got %b want 0", bus8.done);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        int seen = 0;
        launch8(8'hAA, 8'h55, OP_ADD);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow} !== 12'h000) begin
            miscompares++;
            $display("FAIL rst_mid_run outputs: got %h want 000",
                     {bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus8.done === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rst_no_done: got %0d done cycles want 0", seen);
        end
        launch8(8'hFF, 8'h01, OP_ADD);
        wait_done8(cyc);
        vectors++;
        if ({bus8.result, bus8.cout, bus8.overflow} !== {8'h00, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_then_ff_01 {res,cout,ovf}: got %h want %h",
                     {bus8.result, bus8.cout, bus8.overflow}, {8'h00, 2'b10});
        end
    endtask

    task automatic test_width4;
        int cyc;
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 4'h7; bus4.b = 4'h8; bus4.opcode = OP_SUB;
        @(negedge clk);
        bus4.start = 1'b0;
        cyc = 1;
        while (bus4.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc !== 5) begin
            miscompares++;
            $display("FAIL w4_latency: got %0d want 5", cyc);
        end
        vectors++;
        if ({bus4.result, bus4.cout, bus4.overflow} !== {4'hF, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL w4_sub_7_8 {res,cout,ovf}: got %h want %h",
                     {bus4.result, bus4.cout, bus4.overflow}, {4'hF, 2'b01});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_width4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
